// File: rtl/bram_pkg.sv
// Shared types and helpers for the single-port no-change block RAM.
// Holds the sequencer state type, the output-chain limit and lane parity.
package bram_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam int MAX_OUT_STAGES = 3;

  function automatic logic byte_parity(
    input logic [31:0] data,
    input int          byte_w
  );
    logic p;
    p = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i < byte_w) p ^= data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/bram_out_pipe.sv
// Data/valid/error output register chain of N stages for the RAM.
// N == 0 degenerates to a wire; data holds until a new valid arrives.
module bram_out_pipe
  import bram_pkg::*;
#(
  parameter int W = 18,
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  input  logic         v_i,
  input  logic         e_i,
  output logic [W-1:0] d_o,
  output logic         v_o,
  output logic         e_o
);

  if (N < 0 || N > MAX_OUT_STAGES) begin : g_bad_n
    $error("bram_out_pipe: N out of range");
  end

  if (N == 0) begin : g_pass
    assign d_o = d_i;
    assign v_o = v_i;
    assign e_o = e_i;
  end else begin : g_regs
    logic [W-1:0] d_q [N];
    logic [W-1:0] d_d [N];
    logic [N-1:0] v_q, v_d;
    logic [N-1:0] e_q, e_d;

    always_comb begin
      v_d[0] = v_i;
      d_d[0] = v_i ? d_i : d_q[0];
      e_d[0] = v_i ? e_i : e_q[0];
      for (int s = 1; s < N; s++) begin
        v_d[s] = v_q[s-1];
        d_d[s] = v_q[s-1] ? d_q[s-1] : d_q[s];
        e_d[s] = v_q[s-1] ? e_q[s-1] : e_q[s];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < N; s++) d_q[s] <= '0;
        v_q <= '0;
        e_q <= '0;
      end else begin
        for (int s = 0; s < N; s++) d_q[s] <= d_d[s];
        v_q <= v_d;
        e_q <= e_d;
      end
    end

    assign d_o = d_q[N-1];
    assign v_o = v_q[N-1];
    assign e_o = e_q[N-1];
  end

endmodule

// File: rtl/bram_sp_nc_pipe.sv
// Single-port no-change RAM: byte writes, output chain, clear sequencer.
// Define BRAM_PARITY_EN for one even-parity bit per byte lane.
module bram_sp_nc_pipe
  import bram_pkg::*;
#(
  parameter int DATA_W = 18,
  parameter int BYTE_W = 9,
  parameter int DEPTH = 1024,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int OUT_STAGES = 1,
  parameter INIT_FILE = "",
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                     clka,
  input  logic                     rsta_n,
  input  logic                     ena,
  input  logic [DATA_W/BYTE_W-1:0] wea,
  input  logic [ADDR_W-1:0]        addra,
  input  logic [DATA_W-1:0]        dina,
  output logic                     req_ready,
  output logic [DATA_W-1:0]        douta,
  output logic                     douta_valid,
  input  logic                     clear_start,
  output logic                     busy,
  output logic                     par_err
);

  localparam int NBYTES = DATA_W / BYTE_W;
`ifdef BRAM_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int LW = BYTE_W + PB;
  localparam int SW = NBYTES * LW;

  if (DATA_W % BYTE_W != 0) begin : g_bad_w
    $error("DATA_W must be a multiple of BYTE_W");
  end
  if (OUT_STAGES < 0 || OUT_STAGES > MAX_OUT_STAGES) begin : g_bad_s
    $error("OUT_STAGES out of range");
  end

  logic [SW-1:0] mem [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  function automatic logic [SW-1:0] enc(
    input logic [DATA_W-1:0] d
  );
    logic [SW-1:0] w;
    w = '0;
    for (int i = 0; i < NBYTES; i++) begin
      w[i*LW +: BYTE_W] = d[i*BYTE_W +: BYTE_W];
`ifdef BRAM_PARITY_EN
      w[i*LW+BYTE_W] = byte_parity(
        32'(d[i*BYTE_W +: BYTE_W]), BYTE_W);
`endif
    end
    return w;
  endfunction

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              acc, wr, rd;
  logic [SW-1:0]     wr_word, clr_word;

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_CLEAR);
  assign acc       = ena & req_ready;
  assign wr        = acc & (|wea);
  assign rd        = acc & ~(|wea);
  assign wr_word   = enc(dina);
  assign clr_word  = enc(CLEAR_VAL);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clka) begin
    if (busy) begin
      mem[cnt_q] <= clr_word;
    end else if (wr) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wea[i]) mem[addra][i*LW +: LW] <= wr_word[i*LW +: LW];
      end
    end
  end

  logic [SW-1:0] rword_q, rword_d;
  logic          rv_q, rv_d;

  always_comb begin
    rword_d = rd ? mem[addra] : rword_q;
    rv_d    = rd;
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      rword_q <= '0;
      rv_q    <= 1'b0;
    end else begin
      rword_q <= rword_d;
      rv_q    <= rv_d;
    end
  end

  logic [DATA_W-1:0] rdata;
  logic              rerr;
  logic              perr;

  always_comb begin
    rdata = '0;
    rerr  = 1'b0;
    for (int i = 0; i < NBYTES; i++) begin
      rdata[i*BYTE_W +: BYTE_W] = rword_q[i*LW +: BYTE_W];
`ifdef BRAM_PARITY_EN
      rerr |= rword_q[i*LW+BYTE_W] ^ byte_parity(
        32'(rword_q[i*LW +: BYTE_W]), BYTE_W);
`endif
    end
  end

  bram_out_pipe #(
    .W(DATA_W),
    .N(OUT_STAGES)
  ) u_pipe (
    .clk  (clka),
    .rst_n(rsta_n),
    .d_i  (rdata),
    .v_i  (rv_q),
    .e_i  (rerr),
    .d_o  (douta),
    .v_o  (douta_valid),
    .e_o  (perr)
  );

  assign par_err = perr & douta_valid;

endmodule

// File: tb/tb_bram_sp_nc_pipe.sv
// Directed plus random bench for bram_sp_nc_pipe (DEPTH 16, 1 stage).
// Reference model: word array, pending-read queue and clear progress.
module tb_bram_sp_nc_pipe;

  logic        clka = 1'b0;
  logic        rsta_n = 1'b0;
  logic        ena = 1'b0;
  logic [1:0]  wea = '0;
  logic [3:0]  addra = '0;
  logic [17:0] dina = '0;
  logic        clear_start = 1'b0;
  logic        req_ready, douta_valid, busy, par_err;
  logic [17:0] douta;

  always #5 clka = ~clka;

  bram_sp_nc_pipe #(
    .DATA_W(18), .BYTE_W(9), .DEPTH(16),
    .OUT_STAGES(1), .CLEAR_VAL(18'h0)
  ) dut (
    .clka(clka), .rsta_n(rsta_n), .ena(ena),
    .wea(wea), .addra(addra), .dina(dina),
    .req_ready(req_ready), .douta(douta),
    .douta_valid(douta_valid),
    .clear_start(clear_start), .busy(busy),
    .par_err(par_err)
  );

  typedef struct {
    int          due;
    logic [17:0] d;
    logic        e;
  } rd_t;

  int          errs = 0;
  int          chks = 0;
  int          cyc = 0;
  logic [17:0] mm [16];
  logic        bad [16];
  rd_t         pend [$];
  logic        mbusy = 1'b0;
  int          mcnt = 0;
  logic [17:0] last = '0;
  logic        le = 1'b0;
  int          nb;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    chks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic e, input logic [1:0] w,
                      input logic [3:0] a, input logic [17:0] d,
                      input logic c);
    logic acc, ev;
    rd_t  r;
    ena = e; wea = w; addra = a; dina = d; clear_start = c;
    check("busy", 32'(busy), 32'(mbusy));
    check("req_ready", 32'(req_ready), 32'(!mbusy));
    acc = e && !mbusy;
    if (acc && w != 2'b00) begin
      for (int i = 0; i < 2; i++)
        if (w[i]) mm[a][i*9 +: 9] = d[i*9 +: 9];
      if (w[0]) bad[a] = 1'b0;
    end else if (acc) begin
      r.due = cyc + 2; r.d = mm[a]; r.e = bad[a];
      pend.push_back(r);
    end
    if (mbusy) begin
      mm[mcnt] = '0; bad[mcnt] = 1'b0;
      if (mcnt == 15) mbusy = 1'b0;
      else mcnt++;
    end else if (c) begin
      mbusy = 1'b1; mcnt = 0;
    end
    @(posedge clka); #1; cyc++;
    ev = (pend.size() > 0) && (pend[0].due == cyc);
    if (ev) begin
      last = pend[0].d; le = pend[0].e;
      void'(pend.pop_front());
    end
    check("douta_valid", 32'(douta_valid), 32'(ev));
    check("douta", 32'(douta), 32'(last));
    check("par_err", 32'(par_err), 32'(ev && le));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 2'b00, 4'd0, '0, 0);
  endtask

  task automatic do_reset();
    ena = 0; clear_start = 0;
    rsta_n = 1'b0; #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_douta", 32'(douta), 32'd0);
    check("rst_valid", 32'(douta_valid), 32'd0);
    check("rst_perr", 32'(par_err), 32'd0);
    mbusy = 1'b0; mcnt = 0; pend.delete();
    last = '0; le = 1'b0;
    @(posedge clka); #1; cyc++;
    rsta_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mm[i] = '0; bad[i] = 1'b0;
    end
    do_reset();
    tick(1, 2'b00, 4'd0, '0, 0);
    idle(2);
    for (int i = 0; i < 16; i++)
      tick(1, 2'b11, 4'(i), 18'($urandom), 0);
    tick(1, 2'b11, 4'd3, 18'h12345, 0);
    tick(1, 2'b11, 4'd5, 18'h3FFFF, 0);
    tick(1, 2'b00, 4'd5, '0, 0);
    idle(3);
    check("t1_hold", 32'(douta), 32'h3FFFF);
    tick(1, 2'b01, 4'd5, 18'h00000, 0);
    tick(1, 2'b00, 4'd5, '0, 0);
    idle(2);
    check("t2_lane", 32'(douta), 32'h3FE00);
    tick(1, 2'b00, 4'd3, '0, 0);
    tick(1, 2'b11, 4'd4, 18'h2AAAA, 0);
    idle(3);
    check("t3_nochange", 32'(douta), 32'h12345);
    for (int i = 0; i < 60; i++)
      tick(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), 18'($urandom), 0);
    tick(1, 2'b00, 4'd3, '0, 1);
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) nb++;
      tick(1, 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), 18'($urandom), 0);
    end
    check("t4_busy_len", 32'(nb), 32'd16);
    tick(1, 2'b00, 4'd5, '0, 0);
    idle(2);
    check("t4_cleared", 32'(douta), 32'h0);
    for (int i = 0; i < 16; i++)
      tick(1, 2'b11, 4'(i), 18'($urandom_range(1, 18'h3FFFF)), 0);
    tick(0, 2'b00, 4'd0, '0, 1);
    idle(7);
    check("t5_cnt", 32'(mcnt), 32'd7);
    do_reset();
    for (int i = 0; i < 16; i++) tick(1, 2'b00, 4'(i), '0, 0);
    idle(3);
    for (int i = 0; i < 40; i++)
      tick(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), 18'($urandom), 0);
    for (int i = 0; i < 16; i++) tick(1, 2'b00, 4'(i), '0, 0);
    idle(3);
`ifdef BRAM_PARITY_EN
    dut.mem[2][0] = ~dut.mem[2][0];
    mm[2][0] = ~mm[2][0];
    bad[2] = 1'b1;
    tick(1, 2'b00, 4'd2, '0, 0);
    tick(1, 2'b00, 4'd9, '0, 0);
    idle(3);
`endif
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
